lsu_byte_sequencer: RTL and testbench

//  Load/store sequencer between the RISC-V datapath and the byte-wide data RAM.

---
 rtl/lsu_byte_sequencer_pkg.sv | 35 +++
 rtl/lsu_byte_sequencer_load_extend.sv | 24 ++
 rtl/lsu_byte_sequencer.sv | 164 ++++++++++++++++
 tb/tb_lsu_byte_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_byte_sequencer_pkg.sv
// Purpose : shared funct3 codes, FSM state type and access-size helpers for the LSU byte sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DRAIN,
    S_RESP
  } state_t;

  // Bytes moved for a funct3; illegal codes return 1 but are flagged separately.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3)
      F3_H, F3_HU: size_bytes = 3'd2;
      F3_W:        size_bytes = 3'd4;
      default:     size_bytes = 3'd1;
    endcase
  endfunction

  // Stores have no unsigned variants.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) funct3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    funct3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_byte_sequencer_load_extend.sv
// Purpose : sign/zero extension of assembled load bytes according to funct3.
// Latency : combinational.
// Backpressure: none.
// Ports: funct3 (load type), raw (little-endian assembled bytes), rdata (extended result).
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = raw;
    case (funct3)
      F3_B:    rdata = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   rdata = {24'd0, raw[7:0]};
      F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   rdata = {16'd0, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Purpose : load/store sequencer; one request at a time, moved over a byte-wide RAM port.
// Latency : error 1 cycle, store N+1 cycles, load N+2 cycles from accept to resp_valid.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
// Ports: req_* request channel (valid/ready), resp_* held response channel,
//        mem_* byte RAM port with 1-cycle read latency.
module lsu_byte_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_offset,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

  state_t            state, state_nx;
  logic [1:0]        cnt;
  logic [1:0]        last_idx;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       raw_q;

  logic [31:0]       req_addr;
  logic [2:0]        req_n;
  logic [32:0]       req_last;
  logic              req_err;
  logic              accept;
  logic              cap_en;
  logic [1:0]        cap_idx;
  logic [31:0]       ext_rdata;

  // Last byte address computed in 33 bits so a 32-bit wrap shows up as out-of-range.
  assign req_addr = req_base + req_offset;
  assign req_n    = size_bytes(req_funct3);
  assign req_last = {1'b0, req_addr} + {30'd0, req_n} - 33'd1;

  always_comb begin
    req_err = !funct3_legal(req_we, req_funct3);
    if ((req_n == 3'd2) && req_addr[0])           req_err = 1'b1;
    if ((req_n == 3'd4) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (req_last >= DEPTH)                        req_err = 1'b1;
  end

  assign accept = req_valid & req_ready;

  always_comb begin
    case (f3_q)
      F3_H, F3_HU: last_idx = 2'd1;
      F3_W:        last_idx = 2'd3;
      default:     last_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Read data lags the address by a cycle, so in ACCESS byte cnt-1 is captured;
  // DRAIN exists only to capture the final byte.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    cap_en    = 1'b0;
    cap_idx   = cnt - 2'd1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_err ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = addr_q + ADDR_W'(cnt);
        if (we_q) begin
          case (cnt)
            2'd0:    mem_wdata = wdata_q[7:0];
            2'd1:    mem_wdata = wdata_q[15:8];
            2'd2:    mem_wdata = wdata_q[23:16];
            default: mem_wdata = wdata_q[31:24];
          endcase
        end
        cap_en = !we_q && (cnt != 2'd0);
        if (cnt == last_idx) state_nx = we_q ? S_RESP : S_DRAIN;
      end
      S_DRAIN: begin
        cap_en   = 1'b1;
        cap_idx  = last_idx;
        state_nx = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 2'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      raw_q   <= 32'd0;
    end else if (accept) begin
      cnt     <= 2'd0;
      addr_q  <= req_addr[ADDR_W-1:0];
      we_q    <= req_we;
      f3_q    <= req_funct3;
      wdata_q <= req_wdata;
      err_q   <= req_err;
      raw_q   <= 32'd0;
    end else begin
      if (state == S_ACCESS) cnt <= (cnt == last_idx) ? 2'd0 : cnt + 2'd1;
      if (cap_en) begin
        case (cap_idx)
          2'd0:    raw_q[7:0]   <= mem_rdata;
          2'd1:    raw_q[15:8]  <= mem_rdata;
          2'd2:    raw_q[23:16] <= mem_rdata;
          default: raw_q[31:24] <= mem_rdata;
        endcase
      end
    end
  end

  load_extend u_load_extend (
    .funct3 (f3_q),
    .raw    (raw_q),
    .rdata  (ext_rdata)
  );

  assign resp_err   = (state == S_RESP) && err_q;
  assign resp_rdata = ((state == S_RESP) && !err_q && !we_q) ? ext_rdata : 32'd0;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
module tb_lsu_byte_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ram     [0:4095] = '{default: 8'h00};
  logic [7:0] ref_mem [0:4095] = '{default: 8'h00};

  lsu_byte_sequencer #(.ADDR_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_err"},   32'(resp_err),   32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    chk({tag, "_mem_en"},     32'(mem_en),     32'd0);
    chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
    chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
  endtask

  // Reference: what a load/store should do, straight from the ISA rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, output logic err, output int nbytes,
                       output logic [31:0] rdata, output logic [31:0] addr);
    bit legal;
    int v, b;
    addr   = base + off;
    nbytes = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
    legal  = we ? (f3 <= 2) : (f3 != 3 && f3 != 6 && f3 != 7);
    err    = !legal;
    if (legal && (addr % nbytes) != 0) err = 1'b1;
    if (legal && (longint'(addr) + nbytes > 4096)) err = 1'b1;
    rdata  = 32'd0;
    if (!err && !we) begin
      v = 0;
      for (int i = 0; i < nbytes; i++) v = v + (int'(ref_mem[addr + i]) << (8 * i));
      case (f3)
        3'd0: begin b = v & 255;   rdata = (b >= 128)   ? b - 256   : b; end
        3'd1: begin b = v & 65535; rdata = (b >= 32768) ? b - 65536 : b; end
        3'd4: rdata = v & 255;
        3'd5: rdata = v & 65535;
        default: rdata = v;
      endcase
    end
  endtask

  // Called and returns at posedge+1. Runs one request end to end.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] wdata,
                         input int hold, output logic [31:0] got_rdata, output logic got_err);
    logic        e_err;
    int          e_n, e_lat, cyc, lat, n_acc, acc_bad;
    logic [31:0] e_rdata, e_addr, r0;
    logic [11:0] exp_a;
    logic        err0;
    model(we, f3, base, off, e_err, e_n, e_rdata, e_addr);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; lat = -1; n_acc = 0; acc_bad = 0;
    while (cyc <= 20 && lat < 0) begin
      @(negedge clk);
      if (mem_en) begin
        exp_a = 12'(e_addr + n_acc);
        if (mem_addr !== exp_a || cyc != 1 + n_acc || mem_we !== we ||
            (we && mem_wdata !== 8'(wdata >> (8 * n_acc)))) acc_bad++;
        n_acc++;
      end
      if (mem_we && !mem_en) acc_bad++;
      if (resp_valid) lat = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    e_lat = e_err ? 1 : (we ? e_n + 1 : e_n + 2);
    chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "_mem_pulses"}, 32'(n_acc), e_err ? 32'd0 : 32'(e_n));
    chk({tag, "_mem_seq_bad"}, 32'(acc_bad), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, e_rdata);
    chk({tag, "_err"}, 32'(resp_err), 32'(e_err));
    got_rdata = resp_rdata;
    got_err   = resp_err;
    r0 = resp_rdata; err0 = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, resp_rdata, r0);
      chk({tag, "_hold_err"}, 32'(resp_err), 32'(err0));
      chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_idle_resp_valid"}, 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    if (we && !e_err)
      for (int i = 0; i < e_n; i++) ref_mem[12'(e_addr + i)] = 8'(wdata >> (8 * i));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_base, r_off, r_wd;
    logic [2:0]  legal_f3 [0:4];

    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_base = 32'd0; req_offset = 32'd0; req_wdata = 32'd0;
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    #3 check_reset("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req("sw_100", 1'b1, 3'd2, 32'h100, 32'd4, 32'hDEADBEEF, 0, rd, er);
    chk("sw_100_ram104", 32'(ram[12'h104]), 32'hEF);
    chk("sw_100_ram107", 32'(ram[12'h107]), 32'hDE);
    run_req("lw_104", 1'b0, 3'd2, 32'h104, 32'd0, 32'd0, 0, rd, er);
    chk("lw_104_const", rd, 32'hDEADBEEF);
    run_req("lb_107", 1'b0, 3'd0, 32'h107, 32'd0, 32'd0, 0, rd, er);
    chk("lb_107_const", rd, 32'hFFFFFFDE);
    run_req("lbu_107", 1'b0, 3'd4, 32'h107, 32'd0, 32'd0, 0, rd, er);
    chk("lbu_107_const", rd, 32'h000000DE);
    run_req("lh_106", 1'b0, 3'd1, 32'h106, 32'd0, 32'd0, 0, rd, er);
    chk("lh_106_const", rd, 32'hFFFFDEAD);
    run_req("lh_105", 1'b0, 3'd1, 32'h105, 32'd0, 32'd0, 0, rd, er);
    chk("lh_105_err_const", 32'(er), 32'd1);
    run_req("sw_102", 1'b1, 3'd2, 32'h102, 32'd0, 32'h12345678, 0, rd, er);
    chk("sw_102_err_const", 32'(er), 32'd1);
    run_req("ld_f3_3", 1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 0, rd, er);
    run_req("st_f3_4", 1'b1, 3'd4, 32'h100, 32'd0, 32'h55, 0, rd, er);
    run_req("lw_ffe", 1'b0, 3'd2, 32'hFFE, 32'd0, 32'd0, 0, rd, er);
    run_req("lb_wrap0", 1'b0, 3'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, rd, er);
    chk("lb_wrap0_err_const", 32'(er), 32'd0);
    run_req("lb_high", 1'b0, 3'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 0, rd, er);
    run_req("lw_hold", 1'b0, 3'd2, 32'h104, 32'd0, 32'd0, 5, rd, er);

    // Reset in the second byte cycle of a word store.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_base = 32'h200; req_offset = 32'd0; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ram200", 32'(ram[12'h200]), 32'h44);
    chk("midrst_ram201", 32'(ram[12'h201] == 8'h00 || ram[12'h201] == 8'h33), 32'd1);
    chk("midrst_ram202", 32'(ram[12'h202]), 32'h00);
    chk("midrst_ram203", 32'(ram[12'h203]), 32'h00);
    ref_mem[12'h200] = 8'h44;
    ref_mem[12'h201] = ram[12'h201];
    run_req("post_rst_lw", 1'b0, 3'd2, 32'h200, 32'd0, 32'd0, 0, rd, er);

    for (int t = 0; t < 80; t++) begin
      r_we = 1'($urandom);
      r_f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
      case ($urandom_range(0, 7))
        0:       r_base = 32'hFF8 + $urandom_range(0, 7);
        1:       r_base = 32'hFFFFFFF8 + $urandom_range(0, 7);
        default: r_base = 32'h300 + $urandom_range(0, 63);
      endcase
      r_off = 32'($urandom_range(0, 16)) - 32'd8;
      r_wd  = $urandom;
      run_req("rand", r_we, r_f3, r_base, r_off, r_wd, $urandom_range(0, 2), rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
